// File: rtl/icp_pkg.sv
// Shared definitions for the intcode processor slice: memory FSM states,
// word geometry, opcodes understood by the core, and address helpers.
package icp_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

  localparam logic [31:0] OP_ADD  = 32'd1;
  localparam logic [31:0] OP_MUL  = 32'd2;
  localparam logic [31:0] OP_HALT = 32'd99;

  // Byte address lies inside a memory of 2**addr_w words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + BYTE_SHIFT)) == 32'd0;
  endfunction

endpackage

// File: rtl/icp_mem_array.sv
// DEPTH x 32 word storage: one asynchronous read port, one synchronous write port.
module icp_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem_r [DEPTH];

  // Contents deliberately survive reset, so there is no reset branch here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/icp_mem.sv
// Intcode core memory: host program load, core read/write responder,
// and memory-image dump back to the host once the core halts.
module icp_mem
  import icp_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_en,
  input  logic [31:0] i_rd_addr,
  output logic [31:0] o_rd_data,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_cpu_halted,
  output logic        o_cpu_rst,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_last,
  output logic        o_ld_ready,
  output logic        o_dump_valid,
  output logic [31:0] o_dump_data,
  output logic        o_dump_last,
  input  logic        i_dump_ready,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO  = {(ADDR_W + 1){1'b0}};

  state_t          state_r;
  logic [ADDR_W:0] ld_ptr_r;
  logic [ADDR_W:0] count_r;
  logic [ADDR_W:0] dump_ptr_r;
  logic            run_first_r;
  logic            cpu_rst_r;
  logic            ld_ready_r;
  logic            dump_valid_r;
  logic            done_r;
  logic            err_r;

  logic              rd_in_range_s;
  logic              wr_in_range_s;
  logic              rd_req_s;
  logic              wr_req_s;
  logic              ld_fire_s;
  logic              ld_drop_s;
  logic              dump_fire_s;
  logic              dump_last_s;
  logic              err_set_s;
  logic              arr_wr_en_s;
  logic [ADDR_W-1:0] arr_wr_addr_s;
  logic [31:0]       arr_wr_data_s;
  logic [ADDR_W-1:0] arr_rd_addr_s;
  logic [31:0]       arr_rd_data_s;

  // Request qualification: the core port only exists while the core runs.
  always_comb begin
    rd_in_range_s = addr_in_range(i_rd_addr, ADDR_W);
    wr_in_range_s = addr_in_range(i_wr_addr, ADDR_W);
    rd_req_s      = (state_r == S_RUN) && i_rd_en;
    wr_req_s      = (state_r == S_RUN) && i_wr_en;
    ld_fire_s     = (state_r == S_LOAD) && i_ld_valid && ld_ready_r;
    ld_drop_s     = ld_fire_s && (ld_ptr_r == DEPTH_CNT);
    dump_last_s   = dump_valid_r && (dump_ptr_r == (count_r - PTR_ONE));
    dump_fire_s   = dump_valid_r && i_dump_ready;
    err_set_s     = (rd_req_s && !rd_in_range_s) || (wr_req_s && !wr_in_range_s);
  end

  // Single write port shared between the load stream and the core.
  always_comb begin
    arr_wr_en_s   = 1'b0;
    arr_wr_addr_s = {ADDR_W{1'b0}};
    arr_wr_data_s = 32'd0;
    case (state_r)
      S_LOAD: begin
        arr_wr_en_s   = ld_fire_s && !ld_drop_s;
        arr_wr_addr_s = ld_ptr_r[ADDR_W-1:0];
        arr_wr_data_s = i_ld_data;
      end
      S_RUN: begin
        arr_wr_en_s   = wr_req_s && wr_in_range_s;
        arr_wr_addr_s = i_wr_addr[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
        arr_wr_data_s = i_wr_data;
      end
      default: begin
        arr_wr_en_s   = 1'b0;
        arr_wr_addr_s = {ADDR_W{1'b0}};
        arr_wr_data_s = 32'd0;
      end
    endcase
  end

  // Read port follows the dump pointer while dumping, the core otherwise.
  always_comb begin
    if (state_r == S_DUMP) begin
      arr_rd_addr_s = dump_ptr_r[ADDR_W-1:0];
    end else begin
      arr_rd_addr_s = i_rd_addr[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
    end
  end

  icp_mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (i_clk),
    .wr_en   (arr_wr_en_s),
    .wr_addr (arr_wr_addr_s),
    .wr_data (arr_wr_data_s),
    .rd_addr (arr_rd_addr_s),
    .rd_data (arr_rd_data_s)
  );

  // Sequencer: load -> run -> dump -> done, with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= S_LOAD;
      ld_ptr_r     <= PTR_ZERO;
      count_r      <= PTR_ZERO;
      dump_ptr_r   <= PTR_ZERO;
      run_first_r  <= 1'b0;
      cpu_rst_r    <= 1'b1;
      ld_ready_r   <= 1'b1;
      dump_valid_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          if (ld_fire_s) begin
            if (ld_drop_s) begin
              err_r <= 1'b1;
            end else begin
              ld_ptr_r <= ld_ptr_r + PTR_ONE;
            end
            if (i_ld_last) begin
              count_r     <= ld_drop_s ? ld_ptr_r : (ld_ptr_r + PTR_ONE);
              state_r     <= S_RUN;
              cpu_rst_r   <= 1'b0;
              ld_ready_r  <= 1'b0;
              run_first_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          run_first_r <= 1'b0;
          if (err_set_s) begin
            err_r <= 1'b1;
          end
          // The halted flag is meaningless while the core is still leaving reset.
          if (!run_first_r && i_cpu_halted) begin
            state_r      <= S_DUMP;
            dump_ptr_r   <= PTR_ZERO;
            dump_valid_r <= 1'b1;
          end
        end
        S_DUMP: begin
          if (dump_fire_s) begin
            if (dump_last_s) begin
              state_r      <= S_DONE;
              dump_valid_r <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              dump_ptr_r <= dump_ptr_r + PTR_ONE;
            end
          end
        end
        S_DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          state_r <= S_LOAD;
        end
      endcase
    end
  end

  assign o_rd_data    = (rd_req_s && rd_in_range_s) ? arr_rd_data_s : 32'd0;
  assign o_cpu_rst    = cpu_rst_r;
  assign o_ld_ready   = ld_ready_r;
  assign o_dump_valid = dump_valid_r;
  assign o_dump_data  = dump_valid_r ? arr_rd_data_s : 32'd0;
  assign o_dump_last  = dump_last_s;
  assign o_done       = done_r;
  assign o_err        = err_r;

endmodule
